// File: rtl/uart_rx_receiver.sv
//==============================================================================
// Module   : uart_rx_receiver
// Purpose  : UART serial receive engine, 8x oversampled, 3-sample majority vote
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module uart_rx_receiver #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 RxEn_i,
    input  logic                 AcqSig_i,
    input  logic                 Rx_i,
    output logic [DATA_BITS-1:0] Data_o,
    output logic                 DataValid_o,
    output logic                 ParityErr_o,
    output logic                 FrameErr_o,
    output logic                 Busy_o
);

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_start  = 3'd1;
    localparam logic [2:0] c_st_data   = 3'd2;
    localparam logic [2:0] c_st_parity = 3'd3;
    localparam logic [2:0] c_st_stop   = 3'd4;

    localparam logic [3:0] c_last_data = 4'(DATA_BITS - 1);
    localparam logic [3:0] c_last_stop = 4'(STOP_BITS - 1);
    localparam logic       c_par_odd   = 1'(PARITY_ODD);
    localparam logic [2:0] c_after_data = (PARITY_EN != 0) ? c_st_parity : c_st_stop;

    logic                 r_rx_meta;
    logic                 r_rx_s;
    logic [2:0]           r_state;
    logic [2:0]           r_phase;
    logic [3:0]           r_bit_idx;
    logic                 r_s3;
    logic                 r_s4;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_acc;
    logic                 r_par_err;
    logic                 r_frame_err;
    logic                 r_armed;

    logic                 w_vote;
    logic                 w_mid;
    logic                 w_end;
    logic                 w_ferr;

    // Phase-5 vote uses the live synchronized sample as the third vote
    assign w_vote = (r_s3 & r_s4) | (r_s3 & r_rx_s) | (r_s4 & r_rx_s);
    assign w_mid  = (r_phase == 3'd5);
    assign w_end  = (r_phase == 3'd7);
    assign w_ferr = r_frame_err | ~w_vote;
    assign Busy_o = (r_state != c_st_idle);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_meta   <= 1'b1;
            r_rx_s      <= 1'b1;
            r_state     <= c_st_idle;
            r_phase     <= 3'd0;
            r_bit_idx   <= 4'd0;
            r_s3        <= 1'b1;
            r_s4        <= 1'b1;
            r_shift     <= '0;
            r_par_acc   <= 1'b0;
            r_par_err   <= 1'b0;
            r_frame_err <= 1'b0;
            r_armed     <= 1'b1;
            Data_o      <= '0;
            DataValid_o <= 1'b0;
            ParityErr_o <= 1'b0;
            FrameErr_o  <= 1'b0;
        end else begin
            r_rx_meta   <= Rx_i;
            r_rx_s      <= r_rx_meta;
            DataValid_o <= 1'b0;
            ParityErr_o <= 1'b0;
            FrameErr_o  <= 1'b0;

            if (!RxEn_i) begin
                r_state   <= c_st_idle;
                r_phase   <= 3'd0;
                r_bit_idx <= 4'd0;
                r_armed   <= 1'b1;
            end else if (AcqSig_i) begin
                if (r_state != c_st_idle) begin
                    r_phase <= r_phase + 3'd1;
                    if (r_phase == 3'd3) r_s3 <= r_rx_s;
                    if (r_phase == 3'd4) r_s4 <= r_rx_s;
                end

                case (r_state)
                    c_st_idle: begin
                        if (r_armed && !r_rx_s) begin
                            // This tick is phase 0 of the start bit
                            r_state     <= c_st_start;
                            r_phase     <= 3'd1;
                            r_bit_idx   <= 4'd0;
                            r_par_acc   <= 1'b0;
                            r_par_err   <= 1'b0;
                            r_frame_err <= 1'b0;
                        end else if (r_rx_s) begin
                            r_armed <= 1'b1;
                        end
                    end
                    c_st_start: begin
                        if (w_mid && w_vote) begin
                            r_state <= c_st_idle;
                            r_phase <= 3'd0;
                        end else if (w_end) begin
                            r_state <= c_st_data;
                        end
                    end
                    c_st_data: begin
                        if (w_mid) begin
                            r_shift   <= {w_vote, r_shift[DATA_BITS-1:1]};
                            r_par_acc <= r_par_acc ^ w_vote;
                        end
                        if (w_end) begin
                            if (r_bit_idx == c_last_data) begin
                                r_bit_idx <= 4'd0;
                                r_state   <= c_after_data;
                            end else begin
                                r_bit_idx <= r_bit_idx + 4'd1;
                            end
                        end
                    end
                    c_st_parity: begin
                        if (w_mid) r_par_err <= ((r_par_acc ^ w_vote) != c_par_odd);
                        if (w_end) begin
                            r_bit_idx <= 4'd0;
                            r_state   <= c_st_stop;
                        end
                    end
                    c_st_stop: begin
                        if (w_mid) begin
                            if (r_bit_idx == c_last_stop) begin
                                // Mid-bit exit leaves half a bit to catch the next start edge
                                Data_o      <= r_shift;
                                DataValid_o <= 1'b1;
                                ParityErr_o <= r_par_err;
                                FrameErr_o  <= w_ferr;
                                r_armed     <= ~w_ferr;
                                r_state     <= c_st_idle;
                                r_phase     <= 3'd0;
                                r_bit_idx   <= 4'd0;
                            end else if (!w_vote) begin
                                r_frame_err <= 1'b1;
                            end
                        end
                        if (w_end) r_bit_idx <= r_bit_idx + 4'd1;
                    end
                    default: begin
                        r_state <= c_st_idle;
                        r_phase <= 3'd0;
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_receiver.sv
//==============================================================================
// Module   : tb_uart_rx_receiver
// Purpose  : Directed scoreboard bench for uart_rx_receiver (8N1 and 8E1 builds)
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_rx_receiver;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_en;
    logic       tick;
    logic       rx_a;
    logic       rx_p;
    logic [7:0] data_a, data_p;
    logic       dv_a, pe_a, fe_a, busy_a;
    logic       dv_p, pe_p, fe_p, busy_p;

    int n_checks = 0;
    int n_fail   = 0;
    int cnt_a    = 0;
    int cnt_p    = 0;

    // Expected frames: {data[7:0], parity_err, frame_err}
    logic [9:0] q_a[$];
    logic [9:0] q_p[$];
    logic [9:0] exp_a, exp_p;
    logic [7:0] pat;
    logic       bv;

    always #5 clk = ~clk;

    uart_rx_receiver #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut (
        .clk(clk), .rst(rst), .RxEn_i(rx_en), .AcqSig_i(tick), .Rx_i(rx_a),
        .Data_o(data_a), .DataValid_o(dv_a), .ParityErr_o(pe_a),
        .FrameErr_o(fe_a), .Busy_o(busy_a)
    );

    uart_rx_receiver #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut_p (
        .clk(clk), .rst(rst), .RxEn_i(rx_en), .AcqSig_i(tick), .Rx_i(rx_p),
        .Data_o(data_p), .DataValid_o(dv_p), .ParityErr_o(pe_p),
        .FrameErr_o(fe_p), .Busy_o(busy_p)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Returns 1 ns after the clock edge on which a tick was sampled
    task automatic tick_wait();
        int guard;
        guard = 0;
        do begin
            @(posedge clk);
            guard++;
        end while (!tick && guard < 16);
        if (guard >= 16) check("tick_timeout", {31'b0, tick}, 32'd1);
        #1;
    endtask

    task automatic drive_line(input bit sel, input logic v, input int n);
        if (sel) rx_p = v;
        else     rx_a = v;
        repeat (n) tick_wait();
    endtask

    task automatic send_frame(input bit sel, input logic [7:0] d, input bit pen, input logic pb);
        drive_line(sel, 1'b0, 8);
        for (int i = 0; i < 8; i++) drive_line(sel, d[i], 8);
        if (pen) drive_line(sel, pb, 8);
        drive_line(sel, 1'b1, 8);
    endtask

    initial begin
        tick = 1'b0;
        forever begin
            repeat (3) @(negedge clk);
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (dv_a) begin
            cnt_a++;
            check("sb_a_pending", {31'b0, q_a.size() != 0}, 32'd1);
            if (q_a.size() != 0) begin
                exp_a = q_a.pop_front();
                check("frame_a", {22'b0, data_a, pe_a, fe_a}, {22'b0, exp_a});
            end
        end
        if (dv_p) begin
            cnt_p++;
            check("sb_p_pending", {31'b0, q_p.size() != 0}, 32'd1);
            if (q_p.size() != 0) begin
                exp_p = q_p.pop_front();
                check("frame_p", {22'b0, data_p, pe_p, fe_p}, {22'b0, exp_p});
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst   = 1'b1;
        rx_en = 1'b1;
        rx_a  = 1'b1;
        rx_p  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_a", {20'b0, data_a, dv_a, pe_a, fe_a, busy_a}, 32'd0);
        check("reset_p", {20'b0, data_p, dv_p, pe_p, fe_p, busy_p}, 32'd0);
        rst = 1'b0;
        repeat (4) tick_wait();

        // 8N1 0xA5 with exact completion-tick timing
        q_a.push_back({8'hA5, 1'b0, 1'b0});
        pat = 8'hA5;
        drive_line(1'b0, 1'b0, 8);
        check("a5_busy", {31'b0, busy_a}, 32'd1);
        for (int i = 0; i < 8; i++) drive_line(1'b0, pat[i], 8);
        drive_line(1'b0, 1'b1, 5);
        check("a5_early", {31'b0, dv_a}, 32'd0);
        tick_wait();
        check("a5_pulse", {31'b0, dv_a}, 32'd1);
        check("a5_busy_low", {31'b0, busy_a}, 32'd0);
        @(posedge clk);
        #1;
        check("a5_width", {31'b0, dv_a}, 32'd0);
        drive_line(1'b0, 1'b1, 2);
        check("a5_count", cnt_a, 32'd1);

        // False start: two low ticks then high
        drive_line(1'b0, 1'b0, 1);
        check("fs_busy", {31'b0, busy_a}, 32'd1);
        drive_line(1'b0, 1'b0, 1);
        drive_line(1'b0, 1'b1, 4);
        check("fs_idle", {31'b0, busy_a}, 32'd0);
        drive_line(1'b0, 1'b1, 8);
        check("fs_count", cnt_a, 32'd1);

        // 8E1: bad then good parity
        q_p.push_back({8'h03, 1'b1, 1'b0});
        send_frame(1'b1, 8'h03, 1'b1, 1'b1);
        q_p.push_back({8'h03, 1'b0, 1'b0});
        send_frame(1'b1, 8'h03, 1'b1, 1'b0);
        drive_line(1'b1, 1'b1, 4);
        check("par_count", cnt_p, 32'd2);

        // Break: one frame-error character only, then recovery
        q_a.push_back({8'h00, 1'b0, 1'b1});
        drive_line(1'b0, 1'b0, 160);
        check("brk_count", cnt_a, 32'd2);
        check("brk_busy", {31'b0, busy_a}, 32'd0);
        drive_line(1'b0, 1'b1, 4);
        q_a.push_back({8'h5A, 1'b0, 1'b0});
        send_frame(1'b0, 8'h5A, 1'b0, 1'b0);
        drive_line(1'b0, 1'b1, 2);
        check("brk_recover", cnt_a, 32'd3);

        // 0x55 with a one-tick inverted glitch at phase 4 of every data bit
        q_a.push_back({8'h55, 1'b0, 1'b0});
        pat = 8'h55;
        drive_line(1'b0, 1'b0, 8);
        for (int i = 0; i < 8; i++) begin
            bv = pat[i];
            drive_line(1'b0, bv, 4);
            drive_line(1'b0, ~bv, 1);
            drive_line(1'b0, bv, 3);
        end
        drive_line(1'b0, 1'b1, 8);
        check("glitch_count", cnt_a, 32'd4);

        // Enable drop mid-data
        drive_line(1'b0, 1'b0, 8);
        drive_line(1'b0, 1'b1, 27);
        check("abort_busy_before", {31'b0, busy_a}, 32'd1);
        rx_en = 1'b0;
        @(posedge clk);
        #1;
        check("abort_busy", {31'b0, busy_a}, 32'd0);
        check("abort_data", {24'b0, data_a}, 32'h55);
        rx_en = 1'b1;
        drive_line(1'b0, 1'b1, 16);
        check("abort_count", cnt_a, 32'd4);

        // Reset mid-frame, then clean 0xC3
        drive_line(1'b0, 1'b0, 8);
        drive_line(1'b0, 1'b1, 8);
        drive_line(1'b0, 1'b0, 4);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid_a", {20'b0, data_a, dv_a, pe_a, fe_a, busy_a}, 32'd0);
        rst  = 1'b0;
        rx_a = 1'b1;
        drive_line(1'b0, 1'b1, 8);
        q_a.push_back({8'hC3, 1'b0, 1'b0});
        send_frame(1'b0, 8'hC3, 1'b0, 1'b0);
        drive_line(1'b0, 1'b1, 4);
        check("rst_recover", cnt_a, 32'd5);
        check("sb_a_drained", q_a.size(), 32'd0);
        check("sb_p_drained", q_p.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
